// File: rtl/hazard_if.sv
// Decode/execute hazard signals shared between the pipeline and hazard_ctrl.
// The pipeline side is the master; the hazard controller is the slave.
interface hazard_if;
    logic       DecValid;
    logic [5:0] DecRs1;
    logic [5:0] DecRs2;
    logic       DecUsesRs2;
    logic       DecIsFPULong;
    logic [5:0] ExeRd;
    logic       ExeRegWE;
    logic       ExeIsLoad;
    logic       TakenBranch;
    logic       Stall;
    logic       Bubble;
    logic       Flush;
    logic       FPUBusy;
    logic       FPUDone;

    modport master (
        output DecValid, DecRs1, DecRs2, DecUsesRs2, DecIsFPULong,
        output ExeRd, ExeRegWE, ExeIsLoad, TakenBranch,
        input  Stall, Bubble, Flush, FPUBusy, FPUDone
    );

    modport slave (
        input  DecValid, DecRs1, DecRs2, DecUsesRs2, DecIsFPULong,
        input  ExeRd, ExeRegWE, ExeIsLoad, TakenBranch,
        output Stall, Bubble, Flush, FPUBusy, FPUDone
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one bubble per load-use, FPU_LAT-1 stall cycles
// behind each long FPU op, and IF/ID flush on taken branches when decode moves.
module hazard_ctrl #(
    parameter int FPU_LAT = 4
) (
    input  logic    clk,
    input  logic    reset,
    hazard_if.slave hz
);

    if (FPU_LAT < 2 || FPU_LAT > 15) begin : g_bad_lat
        $error("hazard_ctrl: FPU_LAT must be in 2..15");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADUSE  = 2'd1,
        FPU_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FPU_LAT - 2);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_haz;
    logic       stall, bubble, flush, fpu_busy, fpu_done;

    // f0 lives at address 32, so only address 0 is treated as a non-register.
    always_comb begin
        load_haz = hz.DecValid && hz.ExeIsLoad && hz.ExeRegWE && (hz.ExeRd != 6'd0) &&
                   ((hz.ExeRd == hz.DecRs1) || (hz.DecUsesRs2 && (hz.ExeRd == hz.DecRs2)));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_haz) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = LOADUSE;
                end else if (hz.DecValid && hz.DecIsFPULong) begin
                    cnt_d   = CNT_INIT;
                    state_d = FPU_WAIT;
                end
            end
            // The load has reached MEM; forwarding covers the dependent op.
            LOADUSE: state_d = IDLE;
            FPU_WAIT: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush    = hz.TakenBranch && !stall;
        fpu_busy = (state_q == FPU_WAIT);
        fpu_done = (state_q == FPU_WAIT) && (cnt_q == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks every output combinationally, independent of the inputs.
    assign hz.Stall   = !reset && stall;
    assign hz.Bubble  = !reset && bubble;
    assign hz.Flush   = !reset && flush;
    assign hz.FPUBusy = !reset && fpu_busy;
    assign hz.FPUDone = !reset && fpu_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, all checked
// against a schedule-of-cycles reference model built from the hazard rules.
module tb_hazard_ctrl;
    localparam int FPU_LAT = 4;

    logic clk = 1'b0;
    logic reset;
    hazard_if hif ();

    hazard_ctrl #(.FPU_LAT(FPU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Each queued slot is a cycle whose outcome is already decided.
    typedef struct {
        logic stall;
        logic done;
    } slot_t;
    slot_t sched[$];

    logic e_stall, e_bubble, e_flush, e_busy, e_done;
    logic a_stall, a_bubble, a_flush, a_busy, a_done;
    logic [5:0] pool [4] = '{6'd0, 6'd5, 6'd7, 6'd32};

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic ref_haz();
        return hif.DecValid && hif.ExeIsLoad && hif.ExeRegWE && (hif.ExeRd != 6'd0) &&
               ((hif.ExeRd == hif.DecRs1) || (hif.DecUsesRs2 && (hif.ExeRd == hif.DecRs2)));
    endfunction

    task automatic quiet();
        hif.DecValid     = 1'b0;
        hif.DecRs1       = 6'd0;
        hif.DecRs2       = 6'd0;
        hif.DecUsesRs2   = 1'b0;
        hif.DecIsFPULong = 1'b0;
        hif.ExeRd        = 6'd0;
        hif.ExeRegWE     = 1'b0;
        hif.ExeIsLoad    = 1'b0;
        hif.TakenBranch  = 1'b0;
    endtask

    task automatic load_use(input logic [5:0] rd);
        hif.DecValid  = 1'b1;
        hif.DecRs1    = rd;
        hif.ExeRd     = rd;
        hif.ExeRegWE  = 1'b1;
        hif.ExeIsLoad = 1'b1;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step(input string tag);
        #1;
        if (reset) begin
            e_stall = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        end else if (sched.size() != 0) begin
            e_stall = sched[0].stall;
            e_busy  = sched[0].stall;
            e_done  = sched[0].done;
        end else begin
            e_stall = ref_haz();
            e_busy  = 1'b0;
            e_done  = 1'b0;
        end
        e_bubble = e_stall;
        e_flush  = !reset && hif.TakenBranch && !e_stall;

        a_stall = hif.Stall; a_bubble = hif.Bubble; a_flush = hif.Flush;
        a_busy  = hif.FPUBusy; a_done = hif.FPUDone;
        check({tag, ".Stall"},   8'(a_stall),  8'(e_stall));
        check({tag, ".Bubble"},  8'(a_bubble), 8'(e_bubble));
        check({tag, ".Flush"},   8'(a_flush),  8'(e_flush));
        check({tag, ".FPUBusy"}, 8'(a_busy),   8'(e_busy));
        check({tag, ".FPUDone"}, 8'(a_done),   8'(e_done));

        if (reset) begin
            sched.delete();
        end else if (sched.size() != 0) begin
            sched.delete(0);
        end else if (ref_haz()) begin
            sched.push_back('{1'b0, 1'b0});
        end else if (hif.DecValid && hif.DecIsFPULong) begin
            for (int i = 1; i < FPU_LAT; i++) sched.push_back('{1'b1, logic'(i == FPU_LAT - 1)});
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset with garbage on the inputs: everything must stay low.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hif.DecValid = 1'b1; hif.DecRs1 = 6'd5; hif.DecRs2 = 6'd5;
            hif.DecUsesRs2 = 1'b1; hif.DecIsFPULong = 1'b1; hif.ExeRd = 6'd5;
            hif.ExeRegWE = 1'b1; hif.ExeIsLoad = 1'b1; hif.TakenBranch = 1'b1;
            step("rst");
            check("rst_stall", 8'(a_stall), 8'd0);
            check("rst_flush", 8'(a_flush), 8'd0);
        end
        reset = 1'b0;

        // Basic load-use: one stall, then free with inputs unchanged.
        quiet(); load_use(6'd5);
        step("lu1"); check("lu1_stall", 8'(a_stall), 8'd1); check("lu1_bub", 8'(a_bubble), 8'd1);
        step("lu2"); check("lu2_stall", 8'(a_stall), 8'd0);
        quiet(); step("gap");

        // r0 destination never hazards; rs2 matters only when read.
        quiet(); load_use(6'd0);
        step("r0"); check("r0_stall", 8'(a_stall), 8'd0);
        quiet(); hif.DecValid = 1'b1; hif.DecRs1 = 6'd1; hif.DecRs2 = 6'd7;
        hif.ExeRd = 6'd7; hif.ExeRegWE = 1'b1; hif.ExeIsLoad = 1'b1;
        step("rs2n"); check("rs2n_stall", 8'(a_stall), 8'd0);
        hif.DecUsesRs2 = 1'b1;
        step("rs2y"); check("rs2y_stall", 8'(a_stall), 8'd1);
        quiet(); step("rs2y2"); check("rs2y2_stall", 8'(a_stall), 8'd0);

        // f0 (address 32) is a real register.
        quiet(); load_use(6'd32);
        step("f0"); check("f0_stall", 8'(a_stall), 8'd1);
        quiet(); step("f0b");

        // Long FPU op: issue, then FPU_LAT-1 stall cycles, done on the last.
        quiet(); hif.DecValid = 1'b1; hif.DecIsFPULong = 1'b1;
        step("fi"); check("fi_stall", 8'(a_stall), 8'd0);
        quiet(); hif.TakenBranch = 1'b1;
        for (int i = 0; i < FPU_LAT - 1; i++) begin
            step("fw");
            check("fw_stall", 8'(a_stall), 8'd1);
            check("fw_busy", 8'(a_busy), 8'd1);
            check("fw_done", 8'(a_done), 8'(i == FPU_LAT - 2));
        end
        step("fe"); check("fe_busy", 8'(a_busy), 8'd0); check("fe_flush", 8'(a_flush), 8'd1);

        // Branch in plain IDLE, then branch under a load-use stall.
        quiet(); hif.TakenBranch = 1'b1;
        step("br"); check("br_flush", 8'(a_flush), 8'd1);
        load_use(6'd9);
        step("brs1"); check("brs1_flush", 8'(a_flush), 8'd0);
        step("brs2"); check("brs2_flush", 8'(a_flush), 8'd1);
        quiet(); step("brq");

        // Reset during the second FPU wait cycle.
        quiet(); hif.DecValid = 1'b1; hif.DecIsFPULong = 1'b1;
        step("ri");
        quiet(); step("rw1");
        reset = 1'b1; step("rw2"); check("rw2_busy", 8'(a_busy), 8'd0);
        reset = 1'b0;
        step("rr1"); check("rr1_stall", 8'(a_stall), 8'd0); check("rr1_busy", 8'(a_busy), 8'd0);
        step("rr2"); check("rr2_done", 8'(a_done), 8'd0);

        // Load-use and long FPU op together: bubble first, FPU issues next IDLE.
        quiet(); load_use(6'd3); hif.DecIsFPULong = 1'b1;
        step("lf1"); check("lf1_stall", 8'(a_stall), 8'd1);
        hif.ExeIsLoad = 1'b0;
        step("lf2"); check("lf2_stall", 8'(a_stall), 8'd0); check("lf2_busy", 8'(a_busy), 8'd0);
        step("lf3"); check("lf3_stall", 8'(a_stall), 8'd0);
        quiet();
        for (int i = 0; i < FPU_LAT - 1; i++) begin
            step("lfw"); check("lfw_stall", 8'(a_stall), 8'd1);
        end
        step("lfe"); check("lfe_stall", 8'(a_stall), 8'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            reset            = ($urandom_range(0, 59) == 0);
            hif.DecValid     = ($urandom_range(0, 4) != 0);
            hif.DecRs1       = pool[$urandom_range(0, 3)];
            hif.DecRs2       = pool[$urandom_range(0, 3)];
            hif.DecUsesRs2   = 1'($urandom);
            hif.DecIsFPULong = ($urandom_range(0, 5) == 0);
            hif.ExeRd        = pool[$urandom_range(0, 3)];
            hif.ExeRegWE     = ($urandom_range(0, 3) != 0);
            hif.ExeIsLoad    = 1'($urandom);
            hif.TakenBranch  = ($urandom_range(0, 3) == 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
